// File: rtl/alu_pkg.sv
// Shared ALU opcodes and default datapath width.
package alu_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    OP_PASS = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_MUL  = 3'b011,
    OP_DIV  = 3'b100,
    OP_MOD  = 3'b101,
    OP_AND  = 3'b110,
    OP_OR   = 3'b111
  } op_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and divide-by-zero flag.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2:0]       ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             dz
);

  logic bzero;
  op_e  op;

  assign bzero = (b == '0);
  assign op    = op_e'(ctrl);

  // Divide by zero yields all ones for DIV and A for MOD.
  always_comb begin
    res = '0;
    dz  = 1'b0;
    unique case (op)
      OP_PASS: res = a;
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_MUL:  res = a * b;
      OP_DIV: begin
        dz  = bzero;
        res = bzero ? '1 : a / b;
      end
      OP_MOD: begin
        dz  = bzero;
        res = bzero ? a : a % b;
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu_top.sv
// Registered single-cycle ALU wrapper around alu_core.
module alu_top
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [2:0]       ctrl_i,
  input  logic [WIDTH-1:0] data0_i,
  input  logic [WIDTH-1:0] data1_i,
  output logic [WIDTH-1:0] result_o,
  output logic             div0_o
);

  logic [WIDTH-1:0] res;
  logic             dz;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .ctrl (ctrl_i),
    .a    (data0_i),
    .b    (data1_i),
    .res  (res),
    .dz   (dz)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_o <= '0;
      div0_o   <= 1'b0;
    end else begin
      result_o <= res;
      div0_o   <= dz;
    end
  end

endmodule

// File: tb/tb_alu_top.sv
// Self-checking bench for alu_top with a behavioural reference model.
module tb_alu_top;

  logic       clk;
  logic       rst;
  logic [2:0] ctrl;
  logic [7:0] d0;
  logic [7:0] d1;
  logic [7:0] res;
  logic       dz;

  int checks;
  int errors;

  alu_top #(.WIDTH(8)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .ctrl_i   (ctrl),
    .data0_i  (d0),
    .data1_i  (d1),
    .result_o (res),
    .div0_o   (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int ref_res(int op, int a, int b);
    int m;
    m = 256;
    case (op)
      0: return a;
      1: return (a + b) % m;
      2: return (a - b + m) % m;
      3: return (a * b) % m;
      4: return (b == 0) ? m - 1 : a / b;
      5: return (b == 0) ? a : a % b;
      6: return a & b;
      default: return a | b;
    endcase
  endfunction

  function automatic bit ref_dz(int op, int b);
    return (op == 4 || op == 5) && b == 0;
  endfunction

  task automatic cycle(input int op, input int a,
                       input int b, input bit r);
    @(negedge clk);
    ctrl = 3'(op);
    d0   = 8'(a);
    d1   = 8'(b);
    rst  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cycle(3, 255, 255, 1'b0);
    cycle(7, 255, 255, 1'b1);
    checks++;
    if (res !== 8'd0 || dz !== 1'b0) begin
      errors++;
      $display("FAIL reset: res=%0d dz=%0b want 0 0", res, dz);
    end
  endtask

  task automatic test_directed();
    int op[12] = '{1, 2, 2, 3, 3, 4, 5, 4, 5, 0, 6, 7};
    int a[12]  = '{20, 8, 3, 12, 200, 7, 7, 9, 9, 10, 12, 12};
    int b[12]  = '{10, 8, 5, 2, 2, 3, 3, 0, 0, 0, 10, 3};
    int er[12] = '{30, 0, 254, 24, 144, 2, 1,
                   255, 9, 10, 8, 15};
    bit ed[12] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    for (int i = 0; i < 12; i++) begin
      cycle(op[i], a[i], b[i], 1'b0);
      checks++;
      if (res !== 8'(er[i]) || dz !== ed[i]) begin
        errors++;
        $display("FAIL directed[%0d] op=%0d: res=%0d dz=%0b want %0d %0b",
                 i, op[i], res, dz, er[i], ed[i]);
      end
    end
  endtask

  task automatic test_random();
    int op, a, b;
    for (int i = 0; i < 400; i++) begin
      op = int'($urandom_range(0, 7));
      a  = int'($urandom_range(0, 255));
      b  = ($urandom_range(0, 7) == 0) ? 0 :
           int'($urandom_range(0, 255));
      cycle(op, a, b, 1'b0);
      checks++;
      if (res !== 8'(ref_res(op, a, b)) ||
          dz !== ref_dz(op, b)) begin
        errors++;
        $display("FAIL random op=%0d a=%0d b=%0d: res=%0d dz=%0b want %0d %0b",
                 op, a, b, res, dz, ref_res(op, a, b), ref_dz(op, b));
      end
    end
  endtask

  task automatic test_back_to_back();
    int op, a, b, er;
    bit r, ed;
    for (int i = 0; i < 40; i++) begin
      op = i % 8;
      a  = int'($urandom_range(0, 255));
      b  = (i % 5 == 0) ? 0 : int'($urandom_range(1, 255));
      r  = (i == 13) || (i == 27) || (i == 28);
      er = r ? 0 : ref_res(op, a, b);
      ed = r ? 1'b0 : ref_dz(op, b);
      cycle(op, a, b, r);
      checks++;
      if (res !== 8'(er) || dz !== ed) begin
        errors++;
        $display("FAIL b2b[%0d] op=%0d rst=%0b: res=%0d dz=%0b want %0d %0b",
                 i, op, r, res, dz, er, ed);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst  = 1'b1;
    ctrl = 3'd0;
    d0   = 8'd0;
    d1   = 8'd0;
    repeat (2) @(posedge clk);
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_top.md
ALU_TOP -- requirements
Module: alu_top

Interface
REQ-001 Parameter: WIDTH, 8, operand and result width in bits.
REQ-002 Port: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_i  input  1  reset; synchronous and active-high.
REQ-004 Port: ctrl_i  input  3  operation select code.
REQ-005 Port: data0_i  input  WIDTH  operand A, unsigned.
REQ-006 Port: data1_i  input  WIDTH  operand B, unsigned.
REQ-007 Port: result_o  output  WIDTH  registered operation result.
REQ-008 Port: div0_o  output  1  registered flag; set when a DIV or MOD was executed with operand B equal to zero.

Function
REQ-009 The operation decode SHALL be as follows, with all arithmetic unsigned:
- 000: PASS, result = A.
- 001: ADD, result = (A+B) mod 2^WIDTH; carry discarded.
- 010: SUB, result = (A-B) mod 2^WIDTH; wraps on borrow, e.g. 3-5 = 254.
- 011: MUL, result = low WIDTH bits of A*B.
- 100: DIV, result = floor(A/B).
- 101: MOD, result = A mod B.
- 110: AND, result = A & B.
- 111: OR, result = A | B.
REQ-010 The block SHALL sample ctrl_i, data0_i and data1_i on every rising clock edge when rst_i is low and present the result on result_o one cycle later.
REQ-011 Latency SHALL be exactly 1 cycle, throughput 1 operation per cycle, with no handshake; inputs SHALL be consumed every cycle.
REQ-012 For DIV with B = 0, result SHALL be all ones (8'hFF) and div0_o SHALL be 1.
REQ-013 For MOD with B = 0, result SHALL be A and div0_o SHALL be 1.
REQ-014 div0_o SHALL be 0 for every operation other than DIV or MOD with B = 0; it reflects the same cycle's operation as result_o.
REQ-015 Outputs SHALL hold their last value only as long as the inputs are unchanged; every clock edge recomputes.
REQ-016 The block SHALL have no combinational path from inputs to outputs.

Reset
REQ-017 When rst_i is high at a rising edge, result_o SHALL become 0 and div0_o SHALL become 0, overriding any operation.
REQ-018 Assertion of rst_i mid-stream SHALL discard the operation sampled that cycle; the first operation after release SHALL appear one cycle after the first edge with rst_i low.
REQ-019 Output values before the first reset SHALL be unspecified.

Structure
REQ-020 A shared package alu_pkg SHALL hold the 3-bit opcode constants (OP_PASS, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_AND, OP_OR) and the default width constant.
REQ-021 A purely combinational sub-module alu_core SHALL compute the result and the divide-by-zero flag.
REQ-022 alu_top SHALL contain only the output registers, the reset logic and the alu_core instance.

Verification
REQ-023 Reset: assert rst_i for one edge -> result_o=0, div0_o=0.
REQ-024 ADD and SUB:
- ctrl=001, A=20, B=10 -> result_o=30 after 1 cycle.
- ctrl=010, A=8, B=8 -> result_o=0.
- ctrl=010, A=3, B=5 -> result_o=254.
REQ-025 MUL: ctrl=011, A=12, B=2 -> result_o=24; ctrl=011, A=200, B=2 -> result_o=144.
REQ-026 DIV and MOD: ctrl=100, A=7, B=3 -> result_o=2; ctrl=101, A=7, B=3 -> result_o=1, div0_o=0.
REQ-027 Divide-by-zero: ctrl=100, A=9, B=0 -> result_o=255, div0_o=1; ctrl=101, A=9, B=0 -> result_o=9, div0_o=1; next cycle ctrl=000, A=10 -> result_o=10, div0_o=0.
REQ-028 Back-to-back: change the operation every cycle with rst_i pulsed mid-sequence -> each result appears exactly one cycle after its inputs, and the operation sampled during reset is never output.
